// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 instruction sequencer.
// Both the state decode and the control-word layout live here.
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED, S_18, S_33, S_35, S_32,
        S_01, S_05, S_09, S_00, S_22,
        S_12, S_04, S_21, S_06, S_25,
        S_27, S_07, S_23, S_16, S_P1, S_P2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO   = 2'b00;
    localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
    localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
    localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic       dr;
        logic       sr1mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] pcmux;
        logic [1:0] aluk;
        logic       mio_en;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    // Everything inactive; memory strobes are active-low so they idle high.
    localparam ctrl_t CTRL_IDLE = ctrl_t'(24'h000003);

    function automatic ctrl_t decode_ctrl(input state_t st, input logic wait_done,
                                          input logic first_cycle);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            S_18: begin
                c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.pcmux = PCMUX_INC; c.ld_pc = 1'b1;
            end
            S_33, S_25: begin
                c.mem_oe = 1'b0; c.mio_en = 1'b0; c.ld_mdr = wait_done;
            end
            S_35: begin
                c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
            end
            S_32: c.ld_ben = 1'b1;
            S_01, S_05, S_09: begin
                c.sr1mux = 1'b1; c.dr = 1'b1; c.gate_alu = 1'b1;
                c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.aluk = (st == S_01) ? ALUK_ADD : ((st == S_05) ? ALUK_AND : ALUK_NOT);
            end
            S_22: begin
                c.addr1mux = 1'b1; c.addr2mux = ADDR2_SEXT9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
            end
            S_12: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b0; c.addr2mux = ADDR2_ZERO;
                c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
            end
            S_04: begin
                c.gate_pc = 1'b1; c.dr = 1'b0; c.ld_reg = 1'b1;
            end
            S_21: begin
                c.addr1mux = 1'b1; c.addr2mux = ADDR2_SEXT11; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
            end
            S_06, S_07: begin
                c.sr1mux = 1'b1; c.addr1mux = 1'b0; c.addr2mux = ADDR2_SEXT6;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
            end
            S_27: begin
                c.gate_mdr = 1'b1; c.dr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
            end
            S_23: begin
                c.sr1mux = 1'b0; c.aluk = ALUK_PASSA; c.gate_alu = 1'b1;
                c.mio_en = 1'b1; c.ld_mdr = 1'b1;
            end
            S_16: c.mem_we = 1'b0;
            S_P1: c.ld_led = first_cycle;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/slc3_control_wait.sv
// Per-state cycle counter used to stretch memory strobes and to spot the first
// cycle of a pause; clears on state change and saturates instead of wrapping.
module mem_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    output logic [2:0] count_next,
    output logic       done,
    output logic       done_next
);

    localparam logic [2:0] DONE_VAL = 3'(MEM_WAIT - 1);
    localparam logic [2:0] CNT_MAX  = 3'd7;

    logic [2:0] count_r;
    logic [2:0] count_nx_s;

    // Next count: clear wins, otherwise count up until saturated.
    always_comb begin
        count_nx_s = count_r;
        if (clear) begin
            count_nx_s = 3'd0;
        end else if (enable && (count_r != CNT_MAX)) begin
            count_nx_s = count_r + 3'd1;
        end else begin
            count_nx_s = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 3'd0;
        end else begin
            count_r <= count_nx_s;
        end
    end

    assign count_next = count_nx_s;
    assign done       = (count_r == DONE_VAL);
    assign done_next  = (count_nx_s == DONE_VAL);

endmodule

// File: rtl/slc3_control.sv
// SLC-3 ISDU: Moore sequencer driving datapath loads, gates, mux selects and
// memory strobes. Outputs are registered from the decode of the next state.
module slc3_control
    import slc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       DR,
    output logic       SR1MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    state_t     state_r;
    state_t     state_nx_s;
    ctrl_t      ctrl_r;
    ctrl_t      ctrl_nx_s;
    logic       wait_en_s;
    logic       wait_clear_s;
    logic       wait_done_s;
    logic       wait_done_nx_s;
    logic [2:0] wait_cnt_nx_s;

    // Next-state selection and which states run the wait counter.
    always_comb begin
        state_nx_s = state_r;
        wait_en_s  = 1'b0;
        case (state_r)
            S_HALTED: state_nx_s = Run ? S_18 : S_HALTED;
            S_18:     state_nx_s = S_33;
            S_33: begin
                wait_en_s  = 1'b1;
                state_nx_s = wait_done_s ? S_35 : S_33;
            end
            S_35:     state_nx_s = S_32;
            S_32: begin
                case (Opcode)
                    OP_ADD:   state_nx_s = S_01;
                    OP_AND:   state_nx_s = S_05;
                    OP_NOT:   state_nx_s = S_09;
                    OP_BR:    state_nx_s = S_00;
                    OP_JMP:   state_nx_s = S_12;
                    OP_JSR:   state_nx_s = S_04;
                    OP_LDR:   state_nx_s = S_06;
                    OP_STR:   state_nx_s = S_07;
                    OP_PAUSE: state_nx_s = S_P1;
                    default:  state_nx_s = S_18;
                endcase
            end
            S_01, S_05, S_09, S_22, S_12, S_21, S_27: state_nx_s = S_18;
            S_00:     state_nx_s = BEN ? S_22 : S_18;
            S_04:     state_nx_s = S_21;
            S_06:     state_nx_s = S_25;
            S_25: begin
                wait_en_s  = 1'b1;
                state_nx_s = wait_done_s ? S_27 : S_25;
            end
            S_07:     state_nx_s = S_23;
            S_23:     state_nx_s = S_16;
            S_16: begin
                wait_en_s  = 1'b1;
                state_nx_s = wait_done_s ? S_18 : S_16;
            end
            // The counter marks the first pause cycle so LD_LED pulses only once.
            S_P1: begin
                wait_en_s  = 1'b1;
                state_nx_s = Continue ? S_P2 : S_P1;
            end
            S_P2:     state_nx_s = Continue ? S_P2 : S_18;
            default:  state_nx_s = S_HALTED;
        endcase
    end

    assign wait_clear_s = (state_nx_s != state_r);

    mem_wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk        (clk),
        .rst_n      (reset),
        .clear      (wait_clear_s),
        .enable     (wait_en_s),
        .count_next (wait_cnt_nx_s),
        .done       (wait_done_s),
        .done_next  (wait_done_nx_s)
    );

    assign ctrl_nx_s = decode_ctrl(state_nx_s, wait_done_nx_s, (wait_cnt_nx_s == 3'd0));

    // State and control-word registers; reset forces strobes high immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_HALTED;
            ctrl_r  <= CTRL_IDLE;
        end else begin
            state_r <= state_nx_s;
            ctrl_r  <= ctrl_nx_s;
        end
    end

    assign LD_MAR     = ctrl_r.ld_mar;
    assign LD_MDR     = ctrl_r.ld_mdr;
    assign LD_IR      = ctrl_r.ld_ir;
    assign LD_BEN     = ctrl_r.ld_ben;
    assign LD_CC      = ctrl_r.ld_cc;
    assign LD_REG     = ctrl_r.ld_reg;
    assign LD_PC      = ctrl_r.ld_pc;
    assign LD_LED     = ctrl_r.ld_led;
    assign GatePC     = ctrl_r.gate_pc;
    assign GateMDR    = ctrl_r.gate_mdr;
    assign GateALU    = ctrl_r.gate_alu;
    assign GateMARMUX = ctrl_r.gate_marmux;
    assign DR         = ctrl_r.dr;
    assign SR1MUX     = ctrl_r.sr1mux;
    assign ADDR1MUX   = ctrl_r.addr1mux;
    assign ADDR2MUX   = ctrl_r.addr2mux;
    assign PCMUX      = ctrl_r.pcmux;
    assign ALUK       = ctrl_r.aluk;
    assign MIO_EN     = ctrl_r.mio_en;
    assign Mem_OE     = ctrl_r.mem_oe;
    assign Mem_WE     = ctrl_r.mem_we;

endmodule

// File: tb/tb_slc3_control.sv
// Directed bench for slc3_control (MEM_WAIT=2): per-cycle control-word checks
// against hand-written signatures for each state.
module tb_slc3_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'b0000;
    logic       BEN = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       DR, SR1MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;
    logic [1:0] ADDR2MUX, PCMUX, ALUK;

    int checks = 0;
    int fails  = 0;

    // Signature layout: loads(MAR MDR IR BEN CC REG PC LED) gates(PC MDR ALU MARMUX)
    // DR SR1 A1 | ADDR2 | PCMUX | ALUK | MIO OE WE
    localparam logic [23:0] E_IDLE = 24'b00000000_0000_000_00_00_00_011;
    localparam logic [23:0] E_S18  = 24'b10000010_1000_000_00_00_00_011;
    localparam logic [23:0] E_RD0  = 24'b00000000_0000_000_00_00_00_001;
    localparam logic [23:0] E_RD1  = 24'b01000000_0000_000_00_00_00_001;
    localparam logic [23:0] E_S35  = 24'b00100000_0100_000_00_00_00_011;
    localparam logic [23:0] E_S32  = 24'b00010000_0000_000_00_00_00_011;
    localparam logic [23:0] E_S01  = 24'b00001100_0010_110_00_00_00_011;
    localparam logic [23:0] E_S05  = 24'b00001100_0010_110_00_00_01_011;
    localparam logic [23:0] E_S09  = 24'b00001100_0010_110_00_00_10_011;
    localparam logic [23:0] E_S22  = 24'b00000010_0000_001_10_10_00_011;
    localparam logic [23:0] E_S12  = 24'b00000010_0000_010_00_10_00_011;
    localparam logic [23:0] E_S04  = 24'b00000100_1000_000_00_00_00_011;
    localparam logic [23:0] E_S21  = 24'b00000010_0000_001_11_10_00_011;
    localparam logic [23:0] E_S06  = 24'b10000000_0001_010_01_00_00_011;
    localparam logic [23:0] E_S27  = 24'b00001100_0100_100_00_00_00_011;
    localparam logic [23:0] E_S23  = 24'b01000000_0010_000_00_00_11_111;
    localparam logic [23:0] E_S16  = 24'b00000000_0000_000_00_00_00_010;
    localparam logic [23:0] E_P1L  = 24'b00000001_0000_000_00_00_00_011;

    slc3_control #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .Run(Run), .Continue(Continue), .Opcode(Opcode), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .DR(DR), .SR1MUX(SR1MUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .PCMUX(PCMUX),
        .ALUK(ALUK), .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] sig();
        return {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, DR, SR1MUX, ADDR1MUX,
                ADDR2MUX, PCMUX, ALUK, MIO_EN, Mem_OE, Mem_WE};
    endfunction

    // Reset into Halted, then present Run with the given opcode/BEN at a falling edge.
    task automatic launch(input logic [3:0] op, input logic ben);
        reset = 1'b0; Run = 1'b0; Continue = 1'b0;
        @(negedge clk);
        reset = 1'b1; Opcode = op; BEN = ben; Run = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; Run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sig() !== E_IDLE) begin
                $display("FAIL reset_low[%0d]: got %b expected %b", i, sig(), E_IDLE); fails++;
            end
            checks++;
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sig() !== E_IDLE) begin
                $display("FAIL halted_idle[%0d]: got %b expected %b", i, sig(), E_IDLE); fails++;
            end
            checks++;
        end
    endtask

    task automatic test_alu_ops();
        logic [23:0] exp [$];
        logic [3:0]  ops [3] = '{4'b0001, 4'b0101, 4'b1001};
        logic [23:0] res [3] = '{E_S01, E_S05, E_S09};
        for (int k = 0; k < 3; k++) begin
            exp = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, res[k], E_S18};
            launch(ops[k], 1'b0);
            foreach (exp[i]) begin
                @(negedge clk); Run = 1'b0;
                if (sig() !== exp[i]) begin
                    $display("FAIL alu_op%0d[%0d]: got %b expected %b", k, i, sig(), exp[i]); fails++;
                end
                checks++;
            end
        end
    endtask

    task automatic test_branch();
        logic [23:0] exp [$];
        for (int k = 0; k < 2; k++) begin
            if (k == 0) exp = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, E_IDLE, E_S22, E_S18};
            else        exp = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, E_IDLE, E_S18};
            launch(4'b0000, (k == 0) ? 1'b1 : 1'b0);
            foreach (exp[i]) begin
                @(negedge clk); Run = 1'b0;
                if (sig() !== exp[i]) begin
                    $display("FAIL br_ben%0d[%0d]: got %b expected %b", 1 - k, i, sig(), exp[i]); fails++;
                end
                checks++;
            end
        end
    endtask

    task automatic test_jumps();
        logic [23:0] exp [$];
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin exp = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, E_S12, E_S18}; launch(4'b1100, 1'b0); end
                1: begin exp = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, E_S04, E_S21, E_S18}; launch(4'b0100, 1'b0); end
                default: begin exp = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, E_S18}; launch(4'b1111, 1'b0); end
            endcase
            foreach (exp[i]) begin
                @(negedge clk); Run = 1'b0;
                if (sig() !== exp[i]) begin
                    $display("FAIL jump%0d[%0d]: got %b expected %b", k, i, sig(), exp[i]); fails++;
                end
                checks++;
            end
        end
    endtask

    task automatic test_load_store();
        logic [23:0] exp [$];
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                exp = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, E_S06, E_RD0, E_RD1, E_S27, E_S18};
                launch(4'b0110, 1'b0);
            end else begin
                exp = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, E_S06, E_S23, E_S16, E_S16, E_S18};
                launch(4'b0111, 1'b0);
            end
            foreach (exp[i]) begin
                @(negedge clk); Run = 1'b0;
                if (sig() !== exp[i]) begin
                    $display("FAIL ldst%0d[%0d]: got %b expected %b", k, i, sig(), exp[i]); fails++;
                end
                checks++;
            end
        end
    endtask

    task automatic test_pause();
        logic [23:0] exp [$];
        logic        cont [$];
        exp  = '{E_S18, E_RD0, E_RD1, E_S35, E_S32, E_P1L, E_IDLE, E_IDLE, E_S18, E_RD0,
                 E_RD1, E_S35, E_S32, E_P1L, E_IDLE, E_IDLE, E_IDLE, E_IDLE, E_S18};
        cont = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        launch(4'b1101, 1'b0);
        Continue = 1'b1;
        foreach (exp[i]) begin
            @(negedge clk); Run = 1'b0;
            if (sig() !== exp[i]) begin
                $display("FAIL pause[%0d]: got %b expected %b", i, sig(), exp[i]); fails++;
            end
            checks++;
            Continue = cont[i];
        end
    endtask

    task automatic test_async_reset();
        launch(4'b0001, 1'b0);
        @(negedge clk); Run = 1'b0;
        if (sig() !== E_S18) begin
            $display("FAIL ar_s18: got %b expected %b", sig(), E_S18); fails++;
        end
        checks++;
        @(posedge clk); #2;
        if (Mem_OE !== 1'b0) begin
            $display("FAIL ar_oe_active: got %b expected 0", Mem_OE); fails++;
        end
        checks++;
        #1 reset = 1'b0;
        #1;
        if (sig() !== E_IDLE) begin
            $display("FAIL ar_immediate: got %b expected %b", sig(), E_IDLE); fails++;
        end
        checks++;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        if (sig() !== E_IDLE) begin
            $display("FAIL ar_halted: got %b expected %b", sig(), E_IDLE); fails++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_jumps();
        test_load_store();
        test_pause();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
